// File: rtl/ex_stage_ctrl.sv
// ex_stage_ctrl: two-stage execute sequencer driving a combinational ALU.
//
// Stage A (operand register) feeds the ALU. Stage B (result register) captures
// alu_out, resolves BEQ/BNE and presents the result downstream.
//
// Optional feature macro: EX_STALL_CNT_EN adds stall_cnt, a saturating count
// of cycles with out_valid && !out_ready.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   in_valid/in_ready              upstream handshake
//   in_op, in_rs, in_opb, in_shamt ALU operands and opcode
//   in_rd, in_br, in_pc4, in_off   destination, branch kind, PC+4, word offset
//   flush                          squash stage A
//   alu_op, alu_in, crs, shamt     to ALU (from stage A registers only)
//   alu_out, zero                  from ALU
//   out_valid/out_ready            downstream handshake
//   out_result, out_rd, out_we     writeback data
//   out_br_taken, out_br_target    branch resolution
//   stall_cnt                      (EX_STALL_CNT_EN only) stall cycle count
module ex_stage_ctrl #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [DW-1:0] in_rs,
    input  logic [DW-1:0] in_opb,
    input  logic [4:0]    in_shamt,
    input  logic [RW-1:0] in_rd,
    input  logic [1:0]    in_br,
    input  logic [DW-1:0] in_pc4,
    input  logic [DW-1:0] in_off,
    input  logic          flush,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_in,
    output logic [DW-1:0] crs,
    output logic [4:0]    shamt,
    input  logic [DW-1:0] alu_out,
    input  logic          zero,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_rd,
    output logic          out_we,
    output logic          out_br_taken,
    output logic [DW-1:0] out_br_target
`ifdef EX_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);
    logic          a_valid_q, a_valid_d;
    logic [3:0]    a_op_q, a_op_d;
    logic [DW-1:0] a_rs_q, a_rs_d, a_opb_q, a_opb_d, a_pc4_q, a_pc4_d, a_off_q, a_off_d;
    logic [4:0]    a_shamt_q, a_shamt_d;
    logic [RW-1:0] a_rd_q, a_rd_d;
    logic [1:0]    a_br_q, a_br_d;
    logic          b_valid_q, b_valid_d, b_taken_q, b_taken_d, b_nobr_q, b_nobr_d;
    logic [DW-1:0] b_result_q, b_result_d, b_target_q, b_target_d;
    logic [RW-1:0] b_rd_q, b_rd_d;
    logic          b_move, a_move, squash, accept, xfer;

    always_comb begin
        b_move   = !b_valid_q || out_ready;
        a_move   = !a_valid_q || b_move;
        // A taken branch leaving B kills the younger instruction in A.
        squash   = b_valid_q && out_ready && b_taken_q;
        in_ready = a_move && !flush && !squash;
        accept   = in_valid && in_ready;
        xfer     = a_valid_q && b_move && !flush && !squash;
        a_valid_d  = accept ? 1'b1 : (xfer || flush || squash) ? 1'b0 : a_valid_q;
        a_op_d     = accept ? in_op    : a_op_q;
        a_rs_d     = accept ? in_rs    : a_rs_q;
        a_opb_d    = accept ? in_opb   : a_opb_q;
        a_shamt_d  = accept ? in_shamt : a_shamt_q;
        a_rd_d     = accept ? in_rd    : a_rd_q;
        a_br_d     = accept ? in_br    : a_br_q;
        a_pc4_d    = accept ? in_pc4   : a_pc4_q;
        a_off_d    = accept ? in_off   : a_off_q;
        b_valid_d  = xfer ? 1'b1 : out_ready ? 1'b0 : b_valid_q;
        b_result_d = xfer ? alu_out : b_result_q;
        b_rd_d     = xfer ? a_rd_q : b_rd_q;
        // Encoding 11 is treated as "no branch", so only 01/10 suppress writes.
        b_nobr_d   = xfer ? (a_br_q != 2'b01 && a_br_q != 2'b10) : b_nobr_q;
        b_taken_d  = xfer ? ((a_br_q == 2'b01 && zero) || (a_br_q == 2'b10 && !zero)) : b_taken_q;
        b_target_d = xfer ? a_pc4_q + {a_off_q[DW-3:0], 2'b00} : b_target_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q  <= 1'b0;
            a_op_q     <= '0;
            a_rs_q     <= '0;
            a_opb_q    <= '0;
            a_shamt_q  <= '0;
            a_rd_q     <= '0;
            a_br_q     <= '0;
            a_pc4_q    <= '0;
            a_off_q    <= '0;
            b_valid_q  <= 1'b0;
            b_result_q <= '0;
            b_rd_q     <= '0;
            b_nobr_q   <= 1'b0;
            b_taken_q  <= 1'b0;
            b_target_q <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_op_q     <= a_op_d;
            a_rs_q     <= a_rs_d;
            a_opb_q    <= a_opb_d;
            a_shamt_q  <= a_shamt_d;
            a_rd_q     <= a_rd_d;
            a_br_q     <= a_br_d;
            a_pc4_q    <= a_pc4_d;
            a_off_q    <= a_off_d;
            b_valid_q  <= b_valid_d;
            b_result_q <= b_result_d;
            b_rd_q     <= b_rd_d;
            b_nobr_q   <= b_nobr_d;
            b_taken_q  <= b_taken_d;
            b_target_q <= b_target_d;
        end
    end

    assign alu_op        = a_op_q;
    assign alu_in        = a_opb_q;
    assign crs           = a_rs_q;
    assign shamt         = a_shamt_q;
    assign out_valid     = b_valid_q;
    assign out_result    = b_result_q;
    assign out_rd        = b_rd_q;
    assign out_we        = b_valid_q && b_rd_q != '0 && b_nobr_q;
    assign out_br_taken  = b_valid_q && b_taken_q;
    assign out_br_target = b_target_q;

`ifdef EX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = (b_valid_q && !out_ready && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ex_stage_ctrl.sv
// tb_ex_stage_ctrl: directed self-checking bench for ex_stage_ctrl with a small ALU model.
module tb_ex_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, zero, out_valid, out_ready, out_we, out_br_taken;
    logic [3:0]  in_op, alu_op;
    logic [31:0] in_rs, in_opb, in_pc4, in_off, alu_in, crs, alu_out, out_result, out_br_target;
    logic [4:0]  in_shamt, shamt, in_rd, out_rd;
    logic [1:0]  in_br;
`ifdef EX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif
    int n_vec = 0;
    int n_err = 0;

    ex_stage_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_opb(in_opb), .in_shamt(in_shamt),
        .in_rd(in_rd), .in_br(in_br), .in_pc4(in_pc4), .in_off(in_off),
        .flush(flush), .alu_op(alu_op), .alu_in(alu_in), .crs(crs), .shamt(shamt),
        .alu_out(alu_out), .zero(zero), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
        .out_br_taken(out_br_taken), .out_br_target(out_br_target)
`ifdef EX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ALU: 0 ADD, 1 SUB, 2 SLL, 3 AND
    always_comb begin
        alu_out = alu_op == 4'd0 ? crs + alu_in :
                  alu_op == 4'd1 ? crs - alu_in :
                  alu_op == 4'd2 ? alu_in << shamt :
                  alu_op == 4'd3 ? crs & alu_in : 32'd0;
        zero    = alu_out == 32'd0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] opb,
                         input logic [4:0] rd, input logic [1:0] br, input logic [31:0] pc4,
                         input logic [31:0] off);
        in_valid = 1'b1;
        in_op    = op;
        in_rs    = rs;
        in_opb   = opb;
        in_shamt = 5'd0;
        in_rd    = rd;
        in_br    = br;
        in_pc4   = pc4;
        in_off   = off;
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_op = 4'd0; in_rs = 32'd0; in_opb = 32'd0; in_shamt = 5'd0;
        in_rd = 5'd0; in_br = 2'd0; in_pc4 = 32'd0; in_off = 32'd0;
        repeat (2) tick;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_we", 32'(out_we), 32'd0);
        check("rst_taken", 32'(out_br_taken), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_in", alu_in, 32'd0);
        check("rst_crs", crs, 32'd0);
        check("rst_shamt", 32'(shamt), 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_rd", 32'(out_rd), 32'd0);
        check("rst_target", out_br_target, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // single ADD 5+7 -> 12, rd=3
        drive(4'd0, 32'd5, 32'd7, 5'd3, 2'b00, 32'd0, 32'd0);
        tick;
        idle;
        check("add_not_yet", 32'(out_valid), 32'd0);
        check("add_crs", crs, 32'd5);
        tick;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_result", out_result, 32'd12);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_we", 32'(out_we), 32'd1);
        check("add_taken", 32'(out_br_taken), 32'd0);
        tick;
        check("add_drained", 32'(out_valid), 32'd0);

        // back-to-back: op k = k + 10, rd = k+1
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(4'd0, 32'(i), 32'd10, 5'(i + 1), 2'b00, 32'd0, 32'd0);
            else idle;
            if (i < 4) check("b2b_in_ready", 32'(in_ready), 32'd1);
            if (i >= 2) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_result", out_result, 32'(i - 2 + 10));
                check("b2b_rd", 32'(out_rd), 32'(i - 1));
            end
            tick;
        end
        check("b2b_drained", 32'(out_valid), 32'd0);

        // backpressure: results 21,22,23 with rd 4,5,6
        out_ready = 1'b0;
        drive(4'd0, 32'd20, 32'd1, 5'd4, 2'b00, 32'd0, 32'd0);
        tick;
        drive(4'd0, 32'd21, 32'd1, 5'd5, 2'b00, 32'd0, 32'd0);
        check("bp_ready_b_empty", 32'(in_ready), 32'd1);
        tick;
        drive(4'd0, 32'd22, 32'd1, 5'd6, 2'b00, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_full", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", out_result, 32'd21);
            check("bp_rd", 32'(out_rd), 32'd4);
            tick;
        end
        check("bp_result_hold", out_result, 32'd21);
`ifdef EX_STALL_CNT_EN
        check("bp_stall_cnt", stall_cnt, 32'd3);
`endif
        out_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(in_ready), 32'd1);
        tick;
        idle;
        check("bp_second", out_result, 32'd22);
        check("bp_second_rd", 32'(out_rd), 32'd5);
        tick;
        check("bp_third", out_result, 32'd23);
        check("bp_third_valid", 32'(out_valid), 32'd1);
        tick;
        check("bp_drained", 32'(out_valid), 32'd0);

        // BEQ taken (9-9=0), younger op in A gets squashed
        drive(4'd1, 32'd9, 32'd9, 5'd0, 2'b01, 32'h100, 32'hFFFF_FFFF);
        tick;
        drive(4'd0, 32'd1, 32'd1, 5'd7, 2'b00, 32'd0, 32'd0);
        tick;
        drive(4'd0, 32'd2, 32'd2, 5'd8, 2'b00, 32'd0, 32'd0);
        check("beq_valid", 32'(out_valid), 32'd1);
        check("beq_taken", 32'(out_br_taken), 32'd1);
        check("beq_target", out_br_target, 32'h0000_00FC);
        check("beq_we", 32'(out_we), 32'd0);
        check("beq_in_ready", 32'(in_ready), 32'd0);
        tick;
        idle;
        for (int i = 0; i < 3; i++) begin
            check("beq_squashed", 32'(out_valid), 32'd0);
            tick;
        end

        // BNE not taken (4-4=0), then rd=0 write, then br=11 treated as none
        drive(4'd1, 32'd4, 32'd4, 5'd5, 2'b10, 32'h200, 32'd3);
        tick;
        drive(4'd0, 32'd1, 32'd1, 5'd0, 2'b00, 32'd0, 32'd0);
        tick;
        drive(4'd3, 32'hF0, 32'h3C, 5'd9, 2'b11, 32'd0, 32'd0);
        check("bne_valid", 32'(out_valid), 32'd1);
        check("bne_taken", 32'(out_br_taken), 32'd0);
        check("bne_we", 32'(out_we), 32'd0);
        check("bne_target", out_br_target, 32'h20C);
        tick;
        idle;
        check("rd0_valid", 32'(out_valid), 32'd1);
        check("rd0_result", out_result, 32'd2);
        check("rd0_we", 32'(out_we), 32'd0);
        tick;
        check("br11_result", out_result, 32'h30);
        check("br11_we", 32'(out_we), 32'd1);
        check("br11_taken", 32'(out_br_taken), 32'd0);
        tick;

        // flush with A full and B full: only B's content completes
        out_ready = 1'b0;
        drive(4'd0, 32'd30, 32'd0, 5'd9, 2'b00, 32'd0, 32'd0);
        tick;
        drive(4'd0, 32'd40, 32'd0, 5'd10, 2'b00, 32'd0, 32'd0);
        tick;
        drive(4'd0, 32'd50, 32'd0, 5'd11, 2'b00, 32'd0, 32'd0);
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick;
        flush = 1'b0;
        idle;
        out_ready = 1'b1;
        #1;
        check("flush_b_valid", 32'(out_valid), 32'd1);
        check("flush_b_result", out_result, 32'd30);
        tick;
        check("flush_dropped1", 32'(out_valid), 32'd0);
        tick;
        check("flush_dropped2", 32'(out_valid), 32'd0);

        // reset mid-stream with B full
        out_ready = 1'b0;
        drive(4'd0, 32'd3, 32'd4, 5'd2, 2'b01, 32'h40, 32'd1);
        tick;
        idle;
        tick;
        check("mid_valid", 32'(out_valid), 32'd1);
        check("mid_target", out_br_target, 32'h44);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", out_result, 32'd0);
        check("mid_rst_target", out_br_target, 32'd0);
        check("mid_rst_crs", crs, 32'd0);
        check("mid_rst_we", 32'(out_we), 32'd0);
`ifdef EX_STALL_CNT_EN
        check("mid_rst_stall_cnt", stall_cnt, 32'd0);
`endif
        tick;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_rel_in_ready", 32'(in_ready), 32'd1);
        tick;
        check("mid_rel_valid", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ex_stage_ctrl.md
Name: ex_stage_ctrl

Overview:
- Execute-stage sequencer; acts as the initiator side of the combinational ALU port set (alu_op, alu_in, crs, shamt -> alu_out, zero).
- Accepts decoded instructions over a valid/ready handshake and holds them in an operand register (stage A) that drives the ALU.
- Captures the ALU result and zero flag in a result register (stage B), then resolves BEQ/BNE.
- Presents results to memory/writeback over a second valid/ready handshake.

Parameters:
DW, 32, datapath width (operands, result, PC)
RW, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  stage A can accept
in_op  in  4  ALU opcode, passed unmodified to alu_op
in_rs  in  DW  first operand, drives crs
in_opb  in  DW  second operand (rt or extended imm), drives alu_in
in_shamt  in  5  shift amount
in_rd  in  RW  destination register index
in_br  in  2  00 none, 01 BEQ, 10 BNE, 11 treated as none
in_pc4  in  DW  PC+4 of the instruction
in_off  in  DW  sign-extended branch offset, in words
flush  in  1  squash stage A
alu_op  out  4  to ALU
alu_in  out  DW  to ALU
crs  out  DW  to ALU
shamt  out  5  to ALU
alu_out  in  DW  from ALU
zero  in  1  from ALU
out_valid  out  1  stage B valid
out_ready  in  1  downstream accepts
out_result  out  DW  captured alu_out
out_rd  out  RW  destination register index
out_we  out  1  out_valid && out_rd != 0 && in_br was none
out_br_taken  out  1  BEQ&&zero or BNE&&!zero
out_br_target  out  DW  pc4 + (off << 2), mod 2^DW

Behaviour:
- Reset (async assert, sync release): A_valid=0, B_valid=0.
  - All registered fields are 0, so alu_op, alu_in, crs, shamt, out_result, out_rd, out_br_target are all 0.
  - out_valid, out_we and out_br_taken are 0.
- Reset mid-operation: both stages are dropped; no output handshake completes.
- ALU ports are driven only from stage A registers, with no combinational path from the in_* inputs. While A_valid=0, the last values are held.
- B_move = !B_valid || out_ready.
- A_move = !A_valid || B_move.
- in_ready = A_move && !flush && !squash.
- Accept: in_valid && in_ready loads stage A.
- Stage B loads alu_out, zero-derived taken, target, rd and br when A_valid && B_move. A_valid clears in the same cycle unless a new request is accepted.
- Latency: accept at edge N gives out_valid high after edge N+1 (2-cycle pipeline). Throughput is 1 per cycle with out_ready held high.
- Backpressure: out_valid=1 && out_ready=0 holds all stage B outputs stable. Stage A holds if valid; in_ready=0 once both stages are full.
- squash = out_valid && out_ready && out_br_taken. On a squash edge:
  - stage A is invalidated and not transferred;
  - in_ready=0 that cycle;
  - stage B loads nothing, so it becomes empty.
- flush=1: stage A is invalidated at the edge and no transfer to B occurs. Stage B is unaffected. flush together with in_valid drops the incoming request.
- Full/empty boundaries:
  - B full, A full, out_ready=0: no movement.
  - B full, A full, out_ready rises: both shift in one edge.
  - Both empty: in_ready=1.
- Branch target arithmetic is unsigned DW-bit with wrap-around; the offset shift discards the top 2 bits.
- out_we is forced 0 for rd=0 and for branches.

Optional Feature:
- Macro EX_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0]. It increments by 1 each cycle where out_valid && !out_ready, saturates at 0xFFFFFFFF, and resets to 0 on rst_n.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 mid-stream with B full -> out_valid=0 immediately, all outputs 0; after release in_ready=1.
- Single op, op=ADD, rs=5, opb=7, rd=3 (ALU model returns 12) -> out_valid two edges after accept, out_result=12, out_rd=3, out_we=1.
- Back-to-back 4 ops with out_ready=1 -> 4 consecutive out_valid cycles. Then out_ready=0 for 3 cycles -> outputs stable, in_ready=0 once both stages are full, no loss or duplication; with EX_STALL_CNT_EN, stall_cnt=3.
- BEQ with pc4=0x100, off=0xFFFFFFFF, zero=1, younger op in A -> out_br_taken=1, out_br_target=0xFC, younger op never appears, in_ready=0 on the handshake cycle.
- BNE with zero=1 -> out_br_taken=0, out_we=0; write with rd=0 -> out_we=0 but out_valid=1.
- flush asserted together with in_valid while A is full -> neither instruction reaches out_valid; B's prior content still completes.
